controller_reader_m: RTL

//  Serial front-end for two NES-style game controllers, sitting behind the SELECT_controller decode.
//  On a poll request it runs the latch/pulse protocol and shifts 8 buttons from each pad.
//  It commits both bytes atomically to snapshot registers.
//  The CPU reads those registers over the shared data bus; the low address bit selects the pad.

---
 rtl/controller_reader_m_pkg.sv | 26 ++
 rtl/controller_reader_m_if.sv | 24 ++
 rtl/controller_reader_m_sync2.sv | 26 ++
 rtl/controller_reader_m.sv | 129 ++++++++++++
 4 files changed

// File: rtl/controller_reader_m_pkg.sv
// Shared definitions for the two-pad serial controller reader: FSM states and
// the button bit layout also used by CPU-side firmware.
package controller_reader_m_pkg;

  localparam int NUM_PADS = 2;
  localparam int PAD_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_PULSE  = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  // Snapshot bit positions, 1 = pressed; the first serial bit lands in [7].
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/controller_reader_m_if.sv
// CPU-side control strobes plus the pad wiring of the controller reader.
interface controller_reader_m_if;
  import controller_reader_m_pkg::*;

  logic                poll;
  logic                cpu_address_lsb;
  logic                write_enable;
  logic                SELECT_controller;
  logic                ctrl_latch;
  logic                ctrl_pulse;
  logic [NUM_PADS-1:0] ctrl_data;
  logic                busy;

  modport slave (
    input  poll, cpu_address_lsb, write_enable, SELECT_controller, ctrl_data,
    output ctrl_latch, ctrl_pulse, busy
  );

  modport master (
    output poll, cpu_address_lsb, write_enable, SELECT_controller, ctrl_data,
    input  ctrl_latch, ctrl_pulse, busy
  );

endinterface

// File: rtl/controller_reader_m_sync2.sv
// Two-flop synchronizer; resets to all ones so idle (unplugged) pads read released.
module sync2_m #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/controller_reader_m.sv
// Scans two NES-style pads with the latch/pulse protocol on request and
// exposes atomically committed snapshots on the CPU data bus.
module controller_reader_m
  import controller_reader_m_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic                    clk_12_5875,
  input  logic                    rst,
  controller_reader_m_if.slave    bus,
  inout  wire  [PAD_BITS-1:0]     data
);

  localparam int CNT_W = $clog2(2 * HALF_PERIOD);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [2:0]       BIT_LAST   = 3'(PAD_BITS - 1);

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [2:0]                         bitn_q, bitn_d;
  logic                               poll_q;
  logic                               latch_q, latch_d;
  logic                               pulse_q, pulse_d;
  logic [NUM_PADS-1:0][PAD_BITS-1:0]  sr_q, sr_d;
  logic [NUM_PADS-1:0][PAD_BITS-1:0]  snap_q, snap_d;
  logic [NUM_PADS-1:0]                sync_data;
  logic                               start;

  sync2_m #(.WIDTH(NUM_PADS)) u_sync (
    .clk   (clk_12_5875),
    .rst_n (rst),
    .d     (bus.ctrl_data),
    .q     (sync_data)
  );

  // A CPU write to the select region is a scan request; its data is ignored.
  assign start = (bus.poll & ~poll_q) | (bus.SELECT_controller & bus.write_enable);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    sr_d    = sr_q;
    snap_d  = snap_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
        end
      end
      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          bitn_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == HALF_LAST) begin
          // Sample at the end of the low phase so the pad output has settled through the synchronizer.
          for (int p = 0; p < NUM_PADS; p++) begin
            sr_d[p] = {sr_q[p][PAD_BITS-2:0], ~sync_data[p]};
          end
          cnt_d   = '0;
          state_d = (bitn_q == BIT_LAST) ? ST_COMMIT : ST_PULSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == HALF_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          bitn_d  = bitn_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        snap_d  = sr_q;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pad lines are decoded from the next state so they leave a flop aligned with the FSM.
  always_comb begin
    latch_d = (state_d == ST_LATCH);
    pulse_d = (state_d == ST_PULSE);
  end

  always_ff @(posedge clk_12_5875 or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      poll_q  <= 1'b0;
      latch_q <= 1'b0;
      pulse_q <= 1'b0;
      sr_q    <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      poll_q  <= bus.poll;
      latch_q <= latch_d;
      pulse_q <= pulse_d;
      sr_q    <= sr_d;
      snap_q  <= snap_d;
    end
  end

  assign bus.ctrl_latch = latch_q;
  assign bus.ctrl_pulse = pulse_q;
  assign bus.busy       = (state_q != ST_IDLE);

  assign data = (bus.SELECT_controller & ~bus.write_enable) ? snap_q[bus.cpu_address_lsb] : 'z;

endmodule
